vram_write_scheduler: RTL
=========================

# vram_write_scheduler

Owns the single write port of the etch-a-sketch video RAM and decides, cycle by cycle, what is written to it. The block has three jobs:
- At reset, and on a clear request, it runs a full-screen clear sweep.
- It turns each new valid touch sample into a square brush stamp of (2·BRUSH_R+1)² pixels, clipped at the screen edges.
- It arbitrates between the clear sweep and the brush.

It sits between the FT6206 touch controller and the block_ram VRAM write port. The display controller's read port is untouched.

## Interface

Parameters:
- DISPLAY_WIDTH, 240, pixels per row.
- DISPLAY_HEIGHT, 320, rows.
- BRUSH_R, 2, brush half-width; the stamp side is 2·BRUSH_R+1. Legal range is 0..7.
- CLEAR_COLOR, 16'h000F, RGB565 value written by a clear.
- ADDR_W, $clog2(DISPLAY_WIDTH·DISPLAY_HEIGHT), VRAM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- touch_valid  in  1  the touch sample is valid this cycle.
- touch_x  in  9  touch column.
- touch_y  in  9  touch row.
- brush_color  in  16  RGB565 color, sampled when a stamp is accepted.
- vram_wr_ena  out  1  VRAM write strobe (registered).
- vram_wr_addr  out  ADDR_W  VRAM write address, equal to y·DISPLAY_WIDTH + x (registered).
- vram_wr_data  out  16  VRAM write data (registered).
- busy  out  1  high in CLEAR or STAMP (registered).
- clearing  out  1  high in CLEAR only (registered).

## Operation

The state machine has three states: CLEAR, IDLE and STAMP.

**Reset**
- While rst is high: state = CLEAR, clear counter = L−1 (L = DISPLAY_WIDTH·DISPLAY_HEIGHT), and the last-point register is invalid.
- All outputs are 0 while rst is high.

**CLEAR**
- Writes CLEAR_COLOR to one address per cycle: L−1, L−2, …, 0.
- After writing address 0, the next state is IDLE.
- clear_req received during CLEAR is ignored; the sweep does not restart.
- Touch input is ignored during CLEAR.
- On exit, the last-point register is invalidated.

**IDLE**
- If clear_req is high, go to CLEAR. Clear has priority over a simultaneous touch_valid, and that touch is dropped.
- Otherwise, if touch_valid is high, the touch is rejected (state stays IDLE, no write) when either of these holds:
  - touch_x ≥ DISPLAY_WIDTH or touch_y ≥ DISPLAY_HEIGHT;
  - (touch_x, touch_y, brush_color) equals the valid last-point register (repeat suppression).
- Otherwise the touch is accepted:
  - latch cx = touch_x, cy = touch_y, color = brush_color;
  - set dx = dy = −BRUSH_R;
  - update the last-point register;
  - go to STAMP.

**STAMP**
- One offset is processed per cycle, in raster order: dx increments fastest, from −BRUSH_R to +BRUSH_R, then dy increments.
- px = cx+dx and py = cy+dy are computed as 11-bit signed values.
- The offset produces a write only if 0 ≤ px < DISPLAY_WIDTH and 0 ≤ py < DISPLAY_HEIGHT.
  - Clipped offsets still consume their cycle, with vram_wr_ena = 0.
- The stamp always lasts exactly (2·BRUSH_R+1)² cycles. After the last offset (dx = dy = +BRUSH_R), return to IDLE.
- clear_req in any STAMP cycle aborts the stamp: that cycle's offset is still emitted, the remaining offsets are abandoned, and the next state is CLEAR with the counter at L−1.
- touch_valid during STAMP is ignored. There is no queue.

**Arithmetic**
- The address is computed as py·DISPLAY_WIDTH + px, truncated to ADDR_W.
- It is only ever emitted for in-bounds pixels, so it never exceeds L−1.

## Timing

- Outputs are registered. The write for the state/counter value in cycle n appears on vram_wr_* in cycle n+1.
- busy and clearing are asserted in the same cycle as the corresponding writes appear.

**Reset clear**
- The first clock edge with rst low presents addr = L−1, ena = 1.
- Writes run for L consecutive cycles.
- Cycle L+1 after the rst release has ena = 0 and busy = 0.

**Touch latency**
- A touch accepted at edge k produces its first stamp output at edge k+2.
- With BRUSH_R = 2 the stamp output window is 25 cycles.
- The block accepts a new touch on the first IDLE cycle after the window.

**Other rules**
- No two writes are ever issued to the port in the same cycle.
- vram_wr_data is a don't-care when ena = 0, but it is driven to 0.
- An rst assertion in any state, mid-clear or mid-stamp, takes effect at the next edge and restarts the full clear.

## Test plan

- **Reset sweep.** Release rst → exactly 76 800 writes of 16'h000F, addresses 76 799 down to 0, contiguous; then busy = 0. Every address is hit once.
- **Centre stamp (BRUSH_R = 2).** Touch (100, 50), color 16'hF81F → 25 writes. The first address is 48·240+98 = 11 618 and the last is 52·240+102 = 12 582. Order is raster; all data = F81F.
- **Corner clip.** Touch (0, 0) → 25 stamp cycles with exactly 9 writes, at addresses {0, 1, 2, 240, 241, 242, 480, 481, 482}. Touch (239, 319) → 9 writes, the last at 76 799.
- **Rejection.**
  - Touch (240, 10) → no writes, state stays IDLE.
  - Touch (100, 50) twice with the same color → the second is suppressed.
  - The same point with a new color → a fresh 25-write stamp.
- **Clear abort.** clear_req on the 5th stamp cycle → 5 stamp writes, then a full clear starting at 76 799. A touch at (100, 50) after the clear is accepted again, because the last-point register was invalidated.
- **Simultaneous and mid-sweep events.**
  - clear_req and touch_valid in the same IDLE cycle → clear only.
  - rst pulsed mid-clear → the sweep restarts at 76 799.
  - clear_req mid-clear → ignored; the sweep still ends after its original count.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Sole owner of the video RAM write port. Runs a full-screen clear sweep
//   after reset or on request, turns accepted touch samples into a square
//   brush stamp of (2*BRUSH_R+1)^2 pixels clipped at the screen edges, and
//   arbitrates between the two.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   clear_req       one-cycle pulse requesting a full-screen clear
//   touch_valid     touch sample valid this cycle
//   touch_x/_y      touch column / row
//   brush_color     RGB565 stamp color, sampled when a stamp is accepted
//   vram_wr_ena     write strobe (registered)
//   vram_wr_addr    y*DISPLAY_WIDTH + x (registered)
//   vram_wr_data    write data, 0 when no write (registered)
//   busy            high while clearing or stamping (registered)
//   clearing        high while clearing (registered)
//
// All outputs are registered directly from the next-state logic, so the
// write for the state held in cycle n shows up on the port in cycle n+1.

module vram_write_scheduler #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter int          BRUSH_R        = 2,
  parameter logic [15:0] CLEAR_COLOR    = 16'h000F,
  parameter int          ADDR_W         = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              touch_valid,
  input  logic [8:0]        touch_x,
  input  logic [8:0]        touch_y,
  input  logic [15:0]       brush_color,
  output logic              vram_wr_ena,
  output logic [ADDR_W-1:0] vram_wr_addr,
  output logic [15:0]       vram_wr_data,
  output logic              busy,
  output logic              clearing
);

  localparam int                 L    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(L - 1);
  localparam logic [ADDR_W-1:0]  WA   = ADDR_W'(DISPLAY_WIDTH);
  localparam logic [9:0]         W10  = 10'(DISPLAY_WIDTH);
  localparam logic [9:0]         H10  = 10'(DISPLAY_HEIGHT);
  localparam logic signed [10:0] W11  = 11'(DISPLAY_WIDTH);
  localparam logic signed [10:0] H11  = 11'(DISPLAY_HEIGHT);
  // Offsets span -7..+7, so 5 signed bits are enough.
  localparam logic signed [4:0]  R5   = 5'(BRUSH_R);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_STAMP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic [8:0]        cx, cx_n, cy, cy_n;
  logic [15:0]       color, color_n;
  logic signed [4:0] dx, dx_n, dy, dy_n;

  // Last accepted point, used to drop repeated identical samples.
  logic              lp_valid, lp_valid_n;
  logic [8:0]        lp_x, lp_x_n, lp_y, lp_y_n;
  logic [15:0]       lp_color, lp_color_n;

  logic              ena_n, busy_n, clearing_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       data_n;

  // Current stamp pixel; 11-bit signed so negative offsets off the top or
  // left edge stay distinguishable from large positive coordinates.
  logic signed [10:0] px, py;
  logic               pix_in;
  logic [ADDR_W-1:0]  stamp_addr;
  logic               touch_on_screen, touch_repeat;

  always_comb begin
    px         = $signed({2'b00, cx}) + 11'(dx);
    py         = $signed({2'b00, cy}) + 11'(dy);
    pix_in     = !px[10] && !py[10] && (px < W11) && (py < H11);
    stamp_addr = ADDR_W'(py[9:0]) * WA + ADDR_W'(px[9:0]);
  end

  assign touch_on_screen = ({1'b0, touch_x} < W10) && ({1'b0, touch_y} < H10);
  assign touch_repeat    = lp_valid && (touch_x == lp_x) && (touch_y == lp_y) &&
                           (brush_color == lp_color);

  always_comb begin
    state_n    = state;
    clr_cnt_n  = clr_cnt;
    cx_n       = cx;
    cy_n       = cy;
    color_n    = color;
    dx_n       = dx;
    dy_n       = dy;
    lp_valid_n = lp_valid;
    lp_x_n     = lp_x;
    lp_y_n     = lp_y;
    lp_color_n = lp_color;
    ena_n      = 1'b0;
    addr_n     = '0;
    data_n     = '0;
    busy_n     = 1'b0;
    clearing_n = 1'b0;

    case (state)
      S_CLEAR: begin
        // Sweep runs top address down to 0; clear_req and touches are
        // ignored so a sweep always completes once started.
        ena_n      = 1'b1;
        addr_n     = clr_cnt;
        data_n     = CLEAR_COLOR;
        busy_n     = 1'b1;
        clearing_n = 1'b1;
        if (clr_cnt == '0) begin
          state_n    = S_IDLE;
          lp_valid_n = 1'b0;
        end else begin
          clr_cnt_n = clr_cnt - 1'b1;
        end
      end

      S_IDLE: begin
        if (clear_req) begin
          state_n   = S_CLEAR;
          clr_cnt_n = LAST;
        end else if (touch_valid && touch_on_screen && !touch_repeat) begin
          cx_n       = touch_x;
          cy_n       = touch_y;
          color_n    = brush_color;
          dx_n       = -R5;
          dy_n       = -R5;
          lp_valid_n = 1'b1;
          lp_x_n     = touch_x;
          lp_y_n     = touch_y;
          lp_color_n = brush_color;
          state_n    = S_STAMP;
        end
      end

      S_STAMP: begin
        busy_n = 1'b1;
        // Clipped offsets still take their cycle so stamp length is fixed.
        if (pix_in) begin
          ena_n  = 1'b1;
          addr_n = stamp_addr;
          data_n = color;
        end
        if (clear_req) begin
          // This cycle's offset is still emitted above; the rest is dropped.
          state_n   = S_CLEAR;
          clr_cnt_n = LAST;
        end else if (dx == R5) begin
          dx_n = -R5;
          if (dy == R5) state_n = S_IDLE;
          else          dy_n    = dy + 5'sd1;
        end else begin
          dx_n = dx + 5'sd1;
        end
      end

      default: begin
        state_n   = S_CLEAR;
        clr_cnt_n = LAST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      clr_cnt      <= LAST;
      cx           <= '0;
      cy           <= '0;
      color        <= '0;
      dx           <= '0;
      dy           <= '0;
      lp_valid     <= 1'b0;
      lp_x         <= '0;
      lp_y         <= '0;
      lp_color     <= '0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      busy         <= 1'b0;
      clearing     <= 1'b0;
    end else begin
      state        <= state_n;
      clr_cnt      <= clr_cnt_n;
      cx           <= cx_n;
      cy           <= cy_n;
      color        <= color_n;
      dx           <= dx_n;
      dy           <= dy_n;
      lp_valid     <= lp_valid_n;
      lp_x         <= lp_x_n;
      lp_y         <= lp_y_n;
      lp_color     <= lp_color_n;
      vram_wr_ena  <= ena_n;
      vram_wr_addr <= addr_n;
      vram_wr_data <= data_n;
      busy         <= busy_n;
      clearing     <= clearing_n;
    end
  end

endmodule
